sprite_compositor: RTL and testbench

//  Parametrised per-pixel compositor: layers NUM_SPRITES rectangular sprites over the background.

---
 rtl/sprite_compositor.sv | 196 +++++++++++++++++++
 tb/tb_sprite_compositor.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
//   Per-pixel compositor that lays NUM_SPRITES rectangular sprites over the
//   background colour. It sits between the VGA timing generator / sprite ROMs
//   and the DAC.
//
//   Sprite geometry is double-buffered. Writes land in shadow registers, and
//   frame_start copies shadow into the active set. Only the active set is used
//   to draw, so a write in the middle of a line cannot tear the picture.
//
//   Pipeline (one pixel per clock, no backpressure):
//     stage 0 : hit test against the active rectangles, local offsets to ROMs
//     stage 1 : keyed transparency, lowest-index priority, collision detect
//   A pixel presented at cycle T produces color at T+2.
//
// Ports
//   Clk, Reset_n            clock; asynchronous active-low reset
//   pix_valid, DrawX, DrawY pixel stream from the VGA controller
//   frame_start             1-cycle vblank pulse, commits shadow -> active
//   wr_en, wr_idx, wr_x, wr_y, wr_w, wr_h, wr_on
//                           sprite register write port (shadow set)
//   wr_err                  1-cycle pulse after a write to a nonexistent sprite
//   spr_offx, spr_offy      per-sprite local offsets to the sprite ROMs
//   spr_data                per-sprite ROM data for those offsets (async read)
//   bkg_color               background colour for the pixel in stage 1
//   color, color_valid      composited pixel and its valid flag
//   collision               sprites that overlapped another opaque sprite
//                           during the previous frame
// -----------------------------------------------------------------------------
module sprite_compositor #(
   parameter int                 NUM_SPRITES = 4,
   parameter int                 COLOR_W     = 16,
   parameter int                 COORD_W     = 10,
   parameter logic [COLOR_W-1:0] KEY_COLOR   = 16'hF81F
) (
   input  logic                           Clk,
   input  logic                           Reset_n,
   input  logic                           pix_valid,
   input  logic [COORD_W-1:0]             DrawX,
   input  logic [COORD_W-1:0]             DrawY,
   input  logic                           frame_start,
   input  logic                           wr_en,
   input  logic [3:0]                     wr_idx,
   input  logic [COORD_W-1:0]             wr_x,
   input  logic [COORD_W-1:0]             wr_y,
   input  logic [COORD_W-1:0]             wr_w,
   input  logic [COORD_W-1:0]             wr_h,
   input  logic                           wr_on,
   output logic                           wr_err,
   output logic [NUM_SPRITES*COORD_W-1:0] spr_offx,
   output logic [NUM_SPRITES*COORD_W-1:0] spr_offy,
   input  logic [NUM_SPRITES*COLOR_W-1:0] spr_data,
   input  logic [COLOR_W-1:0]             bkg_color,
   output logic [COLOR_W-1:0]             color,
   output logic                           color_valid,
   output logic [NUM_SPRITES-1:0]         collision
);

   // ---------------------------------------------------------------- stage 0
   logic [NUM_SPRITES-1:0]         hit_d;
   logic [NUM_SPRITES*COORD_W-1:0] offx_d;
   logic [NUM_SPRITES*COORD_W-1:0] offy_d;

   // stage 0 -> stage 1 registers
   logic [NUM_SPRITES-1:0]         hit_q;
   logic                           pix_valid_q;
   logic [NUM_SPRITES*COORD_W-1:0] offx_q;
   logic [NUM_SPRITES*COORD_W-1:0] offy_q;

   // ---------------------------------------------------------------- stage 1
   logic [NUM_SPRITES-1:0]         opaque;
   logic [COLOR_W-1:0]             win_color;
   logic                           multi_hit;
   logic [NUM_SPRITES-1:0]         coll_add;

   logic [COLOR_W-1:0]             color_q;
   logic                           color_valid_q;
   logic                           wr_err_q;
   logic [NUM_SPRITES-1:0]         acc_q;
   logic [NUM_SPRITES-1:0]         collision_q;

   // wr_idx is 4 bits wide but NUM_SPRITES may be 16, so compare at 5 bits.
   logic                           idx_ok;
   assign idx_ok = ({1'b0, wr_idx} < 5'(NUM_SPRITES));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
         logic [COORD_W-1:0] sx_q, sy_q, sw_q, sh_q;
         logic               son_q;
         logic [COORD_W-1:0] ax_q, ay_q, aw_q, ah_q;
         logic               aon_q;
         logic [COORD_W:0]   x_end, y_end;
         logic               in_x, in_y;

         // Commit reads the shadow value from before the edge, so a write
         // in the same cycle as frame_start waits for the next commit.
         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
               sx_q  <= '0;
               sy_q  <= '0;
               sw_q  <= '0;
               sh_q  <= '0;
               son_q <= 1'b0;
               ax_q  <= '0;
               ay_q  <= '0;
               aw_q  <= '0;
               ah_q  <= '0;
               aon_q <= 1'b0;
            end else begin
               if (frame_start) begin
                  ax_q  <= sx_q;
                  ay_q  <= sy_q;
                  aw_q  <= sw_q;
                  ah_q  <= sh_q;
                  aon_q <= son_q;
               end
               if (wr_en && (wr_idx == 4'(gi))) begin
                  sx_q  <= wr_x;
                  sy_q  <= wr_y;
                  sw_q  <= wr_w;
                  sh_q  <= wr_h;
                  son_q <= wr_on;
               end
            end
         end

         // One extra bit on the far edge: a sprite hanging off the right or
         // bottom of the coordinate space is clipped rather than wrapped.
         assign x_end = {1'b0, ax_q} + {1'b0, aw_q};
         assign y_end = {1'b0, ay_q} + {1'b0, ah_q};
         assign in_x  = (DrawX >= ax_q) && ({1'b0, DrawX} < x_end);
         assign in_y  = (DrawY >= ay_q) && ({1'b0, DrawY} < y_end);

         assign hit_d[gi] = aon_q && (aw_q != '0) && (ah_q != '0) && in_x && in_y;
         assign offx_d[gi*COORD_W +: COORD_W] = hit_d[gi] ? (DrawX - ax_q) : '0;
         assign offy_d[gi*COORD_W +: COORD_W] = hit_d[gi] ? (DrawY - ay_q) : '0;

         assign opaque[gi] = hit_q[gi] && (spr_data[gi*COLOR_W +: COLOR_W] != KEY_COLOR);
      end
   endgenerate

   // Scan from the highest index down so the lowest opaque index wins.
   always_comb begin
      win_color = bkg_color;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (opaque[i]) begin
            win_color = spr_data[i*COLOR_W +: COLOR_W];
         end
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_hit = (opaque & (opaque - NUM_SPRITES'(1))) != '0;
   assign coll_add  = multi_hit ? opaque : '0;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hit_q         <= '0;
         pix_valid_q   <= 1'b0;
         offx_q        <= '0;
         offy_q        <= '0;
         color_q       <= '0;
         color_valid_q <= 1'b0;
         wr_err_q      <= 1'b0;
         acc_q         <= '0;
         collision_q   <= '0;
      end else begin
         hit_q         <= hit_d;
         pix_valid_q   <= pix_valid;
         offx_q        <= offx_d;
         offy_q        <= offy_d;
         color_valid_q <= pix_valid_q;
         // Blanking pixels leave the last visible colour on the output.
         if (pix_valid_q) begin
            color_q <= win_color;
         end
         wr_err_q <= wr_en && !idx_ok;
         // The overlap seen in the commit cycle still belongs to the old frame.
         if (frame_start) begin
            collision_q <= acc_q | coll_add;
            acc_q       <= '0;
         end else begin
            acc_q <= acc_q | coll_add;
         end
      end
   end

   assign spr_offx    = offx_q;
   assign spr_offy    = offy_q;
   assign color       = color_q;
   assign color_valid = color_valid_q;
   assign wr_err      = wr_err_q;
   assign collision   = collision_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// -----------------------------------------------------------------------------
// tb_sprite_compositor
//   Scoreboard bench for sprite_compositor (4 sprites, RGB565, 10-bit coords).
//   Every driven pixel pushes its expected output, computed from a small
//   behavioural model of the shadow/active registers; every clock pushes the
//   observed output. Each test task pops and compares the two streams inline.
// -----------------------------------------------------------------------------
module tb_sprite_compositor;

   localparam int          N   = 4;
   localparam logic [15:0] KEY = 16'hF81F;

   logic          Clk         = 1'b0;
   logic          Reset_n     = 1'b0;
   logic          pix_valid   = 1'b0;
   logic [9:0]    DrawX       = '0;
   logic [9:0]    DrawY       = '0;
   logic          frame_start = 1'b0;
   logic          wr_en       = 1'b0;
   logic [3:0]    wr_idx      = '0;
   logic [9:0]    wr_x        = '0;
   logic [9:0]    wr_y        = '0;
   logic [9:0]    wr_w        = '0;
   logic [9:0]    wr_h        = '0;
   logic          wr_on       = 1'b0;
   logic          wr_err;
   logic [N*10-1:0] spr_offx;
   logic [N*10-1:0] spr_offy;
   logic [N*16-1:0] spr_data;
   logic [15:0]   bkg_color   = '0;
   logic [15:0]   color;
   logic          color_valid;
   logic [N-1:0]  collision;

   logic [15:0]   rom [N];

   sprite_compositor #(
      .NUM_SPRITES (N),
      .COLOR_W     (16),
      .COORD_W     (10),
      .KEY_COLOR   (KEY)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .pix_valid   (pix_valid),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .frame_start (frame_start),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_w        (wr_w),
      .wr_h        (wr_h),
      .wr_on       (wr_on),
      .wr_err      (wr_err),
      .spr_offx    (spr_offx),
      .spr_offy    (spr_offy),
      .spr_data    (spr_data),
      .bkg_color   (bkg_color),
      .color       (color),
      .color_valid (color_valid),
      .collision   (collision)
   );

   always #5 Clk = ~Clk;

   // Sprite "ROMs": one solid colour per sprite, whatever the offset.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rom
         assign spr_data[gi*16 +: 16] = rom[gi];
      end
   endgenerate

   typedef struct packed {
      logic        v;
      logic [15:0] c;
   } px_t;

   px_t exp_q[$];
   px_t obs_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model state
   int          s_x[N], s_y[N], s_w[N], s_h[N];
   bit          s_on[N];
   int          a_x[N], a_y[N], a_w[N], a_h[N];
   bit          a_on[N];
   logic [15:0] last_c;
   logic [N-1:0] pend, m_acc, m_coll;

   function automatic logic [N-1:0] m_opaque(input int x, input int y);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (a_on[i] && a_w[i] > 0 && a_h[i] > 0 &&
             x >= a_x[i] && x < a_x[i] + a_w[i] &&
             y >= a_y[i] && y < a_y[i] + a_h[i] && rom[i] !== KEY)
            r[i] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [15:0] m_pick(input logic [N-1:0] op);
      for (int i = 0; i < N; i++) begin
         if (op[i]) return rom[i];
      end
      return bkg_color;
   endfunction

   task automatic model_reset();
      px_t e;
      for (int i = 0; i < N; i++) begin
         s_x[i] = 0; s_y[i] = 0; s_w[i] = 0; s_h[i] = 0; s_on[i] = 1'b0;
         a_x[i] = 0; a_y[i] = 0; a_w[i] = 0; a_h[i] = 0; a_on[i] = 1'b0;
      end
      last_c = '0;
      pend   = '0;
      m_acc  = '0;
      m_coll = '0;
      exp_q.delete();
      obs_q.delete();
      // First observation after reset is the flushed pipeline.
      e = '0;
      exp_q.push_back(e);
   endtask

   task automatic set_wr(input int idx, input int x, input int y,
                         input int w, input int h, input bit on);
      wr_en  = 1'b1;
      wr_idx = 4'(idx);
      wr_x   = 10'(x);
      wr_y   = 10'(y);
      wr_w   = 10'(w);
      wr_h   = 10'(h);
      wr_on  = on;
   endtask

   // Called at a falling edge: applies one pixel (plus any pending write),
   // updates the model, waits one clock and records the DUT output.
   task automatic drive(input int x, input int y, input bit v, input bit fs);
      logic [N-1:0] op;
      px_t e, o;
      DrawX       = 10'(x);
      DrawY       = 10'(y);
      pix_valid   = v;
      frame_start = fs;
      op  = m_opaque(x, y);
      e.v = v;
      e.c = v ? m_pick(op) : last_c;
      last_c = e.c;
      exp_q.push_back(e);
      if (fs) begin
         m_coll = m_acc | pend;
         m_acc  = '0;
      end else begin
         m_acc = m_acc | pend;
      end
      pend = ($countones(op) >= 2) ? op : '0;
      if (fs) begin
         a_x = s_x; a_y = s_y; a_w = s_w; a_h = s_h; a_on = s_on;
      end
      if (wr_en && int'(wr_idx) < N) begin
         s_x[wr_idx]  = int'(wr_x);
         s_y[wr_idx]  = int'(wr_y);
         s_w[wr_idx]  = int'(wr_w);
         s_h[wr_idx]  = int'(wr_h);
         s_on[wr_idx] = wr_on;
      end
      @(negedge Clk);
      o.v = color_valid;
      o.c = color;
      obs_q.push_back(o);
      frame_start = 1'b0;
      wr_en       = 1'b0;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      vectors++;
      if (color !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_color: got %h expected 0000", color);
      end
      vectors++;
      if (color_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_color_valid: got %b expected 0", color_valid);
      end
      vectors++;
      if (collision !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_collision: got %b expected 0000", collision);
      end
      vectors++;
      if (wr_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_wr_err: got %b expected 0", wr_err);
      end
      vectors++;
      if (spr_offx !== '0 || spr_offy !== '0) begin
         miscompares++;
         $display("FAIL reset_offsets: got %h/%h expected 0/0", spr_offx, spr_offy);
      end
      model_reset();
      Reset_n = 1'b1;
   endtask

   task automatic test_background();
      px_t o, e;
      bkg_color = 16'h1234;
      drive(10, 10, 1'b1, 1'b0);
      drive(11, 10, 1'b1, 1'b0);
      drive(500, 400, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL background: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
   endtask

   task automatic test_single_sprite();
      px_t o, e;
      rom[0] = 16'hFFFF;
      set_wr(0, 100, 50, 16, 16, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      drive(100, 50, 1'b1, 1'b0);
      vectors++;
      if (spr_offx[9:0] !== 10'd0 || spr_offy[9:0] !== 10'd0) begin
         miscompares++;
         $display("FAIL offset_corner: got %0d,%0d expected 0,0", spr_offx[9:0], spr_offy[9:0]);
      end
      drive(105, 52, 1'b1, 1'b0);
      vectors++;
      if (spr_offx[9:0] !== 10'd5 || spr_offy[9:0] !== 10'd2 || spr_offx[19:10] !== 10'd0) begin
         miscompares++;
         $display("FAIL offset_inner: got %0d,%0d,%0d expected 5,2,0",
                  spr_offx[9:0], spr_offy[9:0], spr_offx[19:10]);
      end
      drive(116, 50, 1'b1, 1'b0);
      vectors++;
      if (spr_offx[9:0] !== 10'd0) begin
         miscompares++;
         $display("FAIL offset_miss: got %0d expected 0", spr_offx[9:0]);
      end
      drive(115, 65, 1'b1, 1'b0);
      drive(100, 66, 1'b1, 1'b0);
      drive(99, 50, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL single_sprite: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
   endtask

   task automatic test_back_to_back();
      px_t o, e;
      for (int x = 96; x < 120; x++) begin
         drive(x, 50, ($urandom_range(0, 3) != 0), 1'b0);
      end
      drive(0, 0, 1'b0, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL back_to_back: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
   endtask

   task automatic test_priority_collision();
      px_t o, e;
      rom[0] = 16'h07E0;
      rom[1] = 16'h001F;
      set_wr(0, 195, 195, 16, 16, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
      set_wr(1, 200, 200, 16, 16, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      drive(200, 200, 1'b1, 1'b0);
      drive(196, 196, 1'b1, 1'b0);
      drive(212, 212, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      vectors++;
      if (collision !== m_coll) begin
         miscompares++;
         $display("FAIL collision_overlap: got %b expected %b", collision, m_coll);
      end
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      vectors++;
      if (collision !== m_coll) begin
         miscompares++;
         $display("FAIL collision_clear: got %b expected %b", collision, m_coll);
      end
      drive(0, 0, 1'b0, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL priority: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
      // Sprite 0 now fully transparent: sprite 1 shows and nothing collides.
      rom[0] = KEY;
      drive(200, 200, 1'b1, 1'b0);
      drive(205, 205, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      vectors++;
      if (collision !== m_coll) begin
         miscompares++;
         $display("FAIL collision_keyed: got %b expected %b", collision, m_coll);
      end
      drive(0, 0, 1'b0, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL keyed: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
   endtask

   task automatic test_commit_same_cycle();
      px_t o, e;
      rom[1] = 16'h07FF;
      set_wr(1, 1020, 300, 16, 4, 1'b1);
      drive(1023, 300, 1'b1, 1'b1);
      drive(1023, 300, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      drive(1020, 300, 1'b1, 1'b0);
      drive(1023, 303, 1'b1, 1'b0);
      drive(0, 300, 1'b1, 1'b0);
      drive(11, 300, 1'b1, 1'b0);
      drive(1023, 304, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL commit_edge: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
   endtask

   task automatic test_wr_err();
      px_t o, e;
      rom[3] = 16'h0F0F;
      set_wr(7, 0, 0, 8, 8, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
      vectors++;
      if (wr_err !== 1'b1) begin
         miscompares++;
         $display("FAIL wr_err_pulse: got %b expected 1", wr_err);
      end
      drive(0, 0, 1'b0, 1'b1);
      vectors++;
      if (wr_err !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_err_clear: got %b expected 0", wr_err);
      end
      drive(0, 0, 1'b1, 1'b0);
      drive(3, 3, 1'b1, 1'b0);
      drive(1023, 300, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL wr_err_regs: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
   endtask

   task automatic test_async_reset();
      px_t o, e;
      rom[2] = 16'hABCD;
      set_wr(2, 1010, 300, 16, 4, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      drive(1021, 301, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      vectors++;
      if (collision !== m_coll) begin
         miscompares++;
         $display("FAIL collision_pair12: got %b expected %b", collision, m_coll);
      end
      drive(1021, 301, 1'b1, 1'b0);
      drive(1022, 301, 1'b1, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL pre_reset: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
      // Mid-line reset, between clock edges.
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      vectors++;
      if (color !== 16'h0 || color_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset_color: got v=%b c=%h expected v=0 c=0000", color_valid, color);
      end
      vectors++;
      if (collision !== 4'b0) begin
         miscompares++;
         $display("FAIL async_reset_collision: got %b expected 0000", collision);
      end
      vectors++;
      if (spr_offx !== '0) begin
         miscompares++;
         $display("FAIL async_reset_offx: got %h expected 0", spr_offx);
      end
      @(negedge Clk);
      model_reset();
      Reset_n = 1'b1;
      drive(1021, 301, 1'b1, 1'b0);
      drive(200, 200, 1'b1, 1'b0);
      drive(100, 50, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      vectors++;
      if (collision !== m_coll) begin
         miscompares++;
         $display("FAIL post_reset_collision: got %b expected %b", collision, m_coll);
      end
      drive(0, 0, 1'b0, 1'b0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL post_reset: got v=%b c=%h expected v=%b c=%h", o.v, o.c, e.v, e.c);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) rom[i] = 16'h0000;
      test_reset();
      test_background();
      test_single_sprite();
      test_back_to_back();
      test_priority_collision();
      test_commit_same_cycle();
      test_wr_err();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
